fetch_unit: RTL

- Instruction-fetch stage directly upstream of the decoder.
- Holds the fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions in a small FIFO and presents them with their PC to decode over a valid/ready handshake.
- Handles control-flow redirects by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/fetch_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order word fetches, buffers returned words with
// their PC in a small FIFO for decode, and discards stale responses after a redirect.
module fetch_unit #(
    parameter int              Xlen           = 32,
    parameter int              Ilen           = 32,
    parameter logic [Xlen-1:0] ResetPc        = '0,
    parameter int              Depth          = 2,
    parameter int              MaxOutstanding = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_valid_i,
    input  logic [Xlen-1:0] redirect_pc_i,
    output logic            imem_valid_o,
    input  logic            imem_ready_i,
    output logic [Xlen-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [Ilen-1:0] imem_rdata_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [Ilen-1:0] inst_o,
    output logic [Xlen-1:0] pc_o
);
    localparam int AW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);
    localparam int OW = $clog2(MaxOutstanding + 1);
    localparam int SW = $clog2(Depth + MaxOutstanding + 1) + 1;

    typedef struct packed {
        logic [Ilen-1:0] inst;
        logic [Xlen-1:0] pc;
    } fifo_entry_t;

    fifo_entry_t     fifo_q [Depth];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [OW-1:0]   outstanding, drop, out_next;
    logic [Xlen-1:0] fetch_pc, resp_pc, redirect_pc;
    logic            credit, accept, rsp_keep, pop, full;

    // Credit reserves a FIFO slot for every request in flight, so a kept
    // response always finds room even if decode never pops.
    assign credit = (SW'(outstanding) + SW'(count) < SW'(Depth)) &&
                    (outstanding < OW'(MaxOutstanding));

    assign imem_valid_o = credit && !redirect_valid_i && !rst_i;
    assign imem_addr_o  = fetch_pc;
    assign accept       = imem_valid_o && imem_ready_i;

    assign inst_valid_o = (count != '0);
    assign inst_o       = fifo_q[rd_ptr].inst;
    assign pc_o         = fifo_q[rd_ptr].pc;

    assign full        = (count == CW'(Depth));
    assign rsp_keep    = imem_rvalid_i && (drop == '0) && !redirect_valid_i;
    assign pop         = inst_valid_o && inst_ready_i && !redirect_valid_i;
    assign out_next    = outstanding + OW'(accept) - OW'(imem_rvalid_i);
    assign redirect_pc = redirect_pc_i & ~Xlen'(3);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc    <= ResetPc;
            resp_pc     <= ResetPc;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect_valid_i) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop     <= out_next;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + Xlen'(4);
                if (imem_rvalid_i && drop != '0)
                    drop <= drop - OW'(1);
                if (rsp_keep) begin
                    wr_ptr  <= wr_ptr + AW'(1);
                    resp_pc <= resp_pc + Xlen'(4);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(rsp_keep) - CW'(pop);
            end
        end
    end

    // Payload storage needs no reset; count gates its visibility.
    always_ff @(posedge clk_i) begin
        if (rsp_keep)
            fifo_q[wr_ptr] <= '{inst: imem_rdata_i, pc: resp_pc};
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(rsp_keep && full && !pop))
                else $error("fetch_unit: enqueue into full instruction fifo");
            assert (!(imem_rvalid_i && outstanding == '0))
                else $error("fetch_unit: response with nothing outstanding");
        end
    end
`endif

endmodule
